serial_tx: RTL and testbench

Transmit end of the EksBox two-wire serial link (SCLK + SDATA). Accepts a parallel word from core logic over a valid/ready handshake, frames it, and drives SCLK/SDATA at a divided rate. The rate is slow enough for a 2-FF synchronizer plus edge detector at the far end to sample every bit. Sits at the EksBox output boundary, opposite the SCLK/SDATA input path.

---
 rtl/serial_tx.sv | 215 +++++++++++++++++++++
 tb/tb_serial_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx -- transmit end of the EksBox two-wire serial link (SCLK + SDATA).
//
// Accepts a parallel word over a valid/ready handshake, frames it as
// start(0) / DATA_W data bits LSB first / [odd parity] / stop(1), and drives
// SCLK/SDATA at 2*CLK_DIV system clocks per bit. SCLK is low for the first
// CLK_DIV cycles of each bit and high for the second; SDATA only changes on
// the falling SCLK edge, so a 2-FF synchronizer plus rising-edge sampler at
// the far end always sees data that has been stable for CLK_DIV cycles.
//
// Optional feature: define SERIAL_TX_PARITY_EN to insert an odd-parity bit
// after the data bits (FRAME_BITS = DATA_W+3 instead of DATA_W+2).
//
// Ports:
//   CLK       in   system clock, posedge
//   ACLR_L    in   asynchronous active-low reset
//   TX_DATA   in   word to send, sampled on the accept edge only
//   TX_VALID  in   requester has a word
//   TX_READY  out  block accepts a word this cycle (registered)
//   SCLK      out  serial clock, idles high (registered)
//   SDATA     out  serial data, idles high (registered)
//   BUSY      out  frame in progress (registered)
//   DONE      out  one-cycle pulse at end of frame (registered)

module serial_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic              CLK,
    input  logic              ACLR_L,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              SCLK,
    output logic              SDATA,
    output logic              BUSY,
    output logic              DONE
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 3;
`else
    localparam int FRAME_BITS = DATA_W + 2;
`endif
    // The start bit is driven directly on accept, so the shift register only
    // holds what follows it: data, optional parity, stop.
    localparam int SH_W  = FRAME_BITS - 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

    generate
        if (CLK_DIV < 3) begin : g_clk_div_check
            $error("serial_tx: CLK_DIV must be >= 3");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

`ifdef SERIAL_TX_PARITY_EN
    // Odd parity: total count of ones over data plus parity bit is odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] data);
        return ~^data;
    endfunction
`endif

    // Everything that follows the start bit, LSB presented first.
    function automatic logic [SH_W-1:0] load_frame(input logic [DATA_W-1:0] data);
`ifdef SERIAL_TX_PARITY_EN
        return {1'b1, odd_parity(data), data};
`else
        return {1'b1, data};
`endif
    endfunction

    state_t            state_r, state_s;
    logic [DIV_W-1:0]  div_r, div_s;
    logic [BIT_W-1:0]  bit_r, bit_s;
    logic [GAP_W-1:0]  gap_r, gap_s;
    logic [SH_W-1:0]   shreg_r, shreg_s;
    logic              sclk_r, sclk_s;
    logic              sdata_r, sdata_s;
    logic              ready_r, ready_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // State and output registers; reset returns the link to idle-high at once.
    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            state_r <= ST_IDLE;
            div_r   <= DIV_ZERO;
            bit_r   <= BIT_ZERO;
            gap_r   <= GAP_ZERO;
            shreg_r <= {SH_W{1'b1}};
            sclk_r  <= 1'b1;
            sdata_r <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            bit_r   <= bit_s;
            gap_r   <= gap_s;
            shreg_r <= shreg_s;
            sclk_r  <= sclk_s;
            sdata_r <= sdata_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        bit_s   = bit_r;
        gap_s   = gap_r;
        shreg_s = shreg_r;
        sclk_s  = sclk_r;
        sdata_s = sdata_r;
        ready_s = ready_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (TX_VALID && ready_r) begin
                    // Start bit goes out on the very next cycle.
                    shreg_s = load_frame(TX_DATA);
                    div_s   = DIV_ZERO;
                    bit_s   = BIT_ZERO;
                    sclk_s  = 1'b0;
                    sdata_s = 1'b0;
                    ready_s = 1'b0;
                    busy_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    sclk_s  = 1'b1;
                    sdata_s = 1'b1;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (div_r == DIV_LAST) begin
                    div_s = DIV_ZERO;
                    if (!sclk_r) begin
                        // Low half done: rising edge, receiver samples here.
                        sclk_s = 1'b1;
                    end else if (bit_r == BIT_LAST) begin
                        // End of stop bit high phase: SCLK simply stays high.
                        sclk_s  = 1'b1;
                        sdata_s = 1'b1;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        bit_s   = BIT_ZERO;
                        if (GAP_CYC == 0) begin
                            ready_s = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            gap_s   = GAP_ZERO;
                            state_s = ST_GAP;
                        end
                    end else begin
                        // Falling edge: present the next bit.
                        sclk_s  = 1'b0;
                        sdata_s = shreg_r[0];
                        shreg_s = {1'b1, shreg_r[SH_W-1:1]};
                        bit_s   = bit_r + BIT_W'(1);
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    gap_s   = GAP_ZERO;
                    ready_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r + GAP_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                div_s   = DIV_ZERO;
                bit_s   = BIT_ZERO;
                gap_s   = GAP_ZERO;
                sclk_s  = 1'b1;
                sdata_s = 1'b1;
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign TX_READY = ready_r;
    assign SCLK     = sclk_r;
    assign SDATA    = sdata_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx. A cycle-level expectation model derived
// from the frame timing rules (time since accept -> bit index and SCLK phase)
// is compared against all outputs every cycle; directed cases pin literal
// waveforms; a second instance with CLK_DIV=3 is looped back through a 2-FF
// synchronizer receiver with 256 random words.
`timescale 1ns/1ps

module tb_serial_tx;

    localparam int DW = 8;
    localparam int CD = 4;
    localparam int GC = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FB  = DW + 3;
    localparam bit PAR = 1'b1;
`else
    localparam int FB  = DW + 2;
    localparam bit PAR = 1'b0;
`endif
    localparam int L     = 2 * CD * FB;
    localparam int LB_CD = 3;
    localparam int LB_GC = 2;
    localparam int LB_N  = 256;

    logic          CLK = 1'b0;
    logic          ACLR_L;
    logic [DW-1:0] TX_DATA;
    logic          TX_VALID;
    logic          TX_READY, SCLK, SDATA, BUSY, DONE;

    logic          lb_rst_n;
    logic [DW-1:0] lb_data;
    logic          lb_valid;
    logic          lb_ready, lb_sclk, lb_sdata, lb_busy, lb_done;

    always #5 CLK = ~CLK;

    serial_tx #(.DATA_W(DW), .CLK_DIV(CD), .GAP_CYC(GC)) u_dut (
        .CLK(CLK), .ACLR_L(ACLR_L), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .SCLK(SCLK), .SDATA(SDATA), .BUSY(BUSY), .DONE(DONE)
    );

    serial_tx #(.DATA_W(DW), .CLK_DIV(LB_CD), .GAP_CYC(LB_GC)) u_lb (
        .CLK(CLK), .ACLR_L(lb_rst_n), .TX_DATA(lb_data), .TX_VALID(lb_valid),
        .TX_READY(lb_ready), .SCLK(lb_sclk), .SDATA(lb_sdata), .BUSY(lb_busy), .DONE(lb_done)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int lb_rx       = 0;
    int lb_done_cnt = 0;
    int lb_busy_cyc = 0;
    bit rx_q[$];
    logic [DW-1:0] lb_sent[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit b of the frame carrying word d.
    function automatic logic fbit(input logic [DW-1:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (PAR && b == DW + 1) return ~^d;
        return 1'b1;
    endfunction

    function automatic logic [FB-1:0] frame_of(input logic [DW-1:0] d);
        logic [FB-1:0] v;
        for (int i = 0; i < FB; i++) v[i] = fbit(d, i);
        return v;
    endfunction

    function automatic logic [FB-1:0] rx_frame(input int off);
        logic [FB-1:0] v;
        v = '0;
        for (int i = 0; i < FB; i++) if (off + i < rx_q.size()) v[i] = rx_q[off + i];
        return v;
    endfunction

    // Expected {TX_READY,SCLK,SDATA,BUSY,DONE}, t cycles after the accept edge.
    function automatic logic [4:0] exp_out(input int t, input logic [DW-1:0] d);
        if (t < L)
            return {1'b0, ((t % (2 * CD)) >= CD), fbit(d, t / (2 * CD)), 1'b1, 1'b0};
        return {(t >= L + GC), 1'b1, 1'b1, 1'b0, (t == L)};
    endfunction

    // The one per-cycle compare process against the behavioural model.
    initial begin : model_check
        int            m_t;
        logic [DW-1:0] m_d, pv_d;
        logic          pv_acc;
        logic [4:0]    exp_v, act_v;
        m_t = L + GC; m_d = '0; pv_d = '0; pv_acc = 1'b0;
        forever begin
            @(negedge CLK);
            if (!ACLR_L) begin
                m_t = L + GC; pv_acc = 1'b0;
            end else if (pv_acc) begin
                m_t = 0; m_d = pv_d;
            end else if (m_t < L + GC) begin
                m_t++;
            end
            exp_v = exp_out(m_t, m_d);
            act_v = {TX_READY, SCLK, SDATA, BUSY, DONE};
            check("cycle_outputs", int'(act_v), int'(exp_v));
            pv_acc = ACLR_L && TX_VALID && exp_v[4];
            pv_d   = TX_DATA;
        end
    end

    // Event monitor: SDATA at SCLK rising edges, DONE pulse count.
    initial begin : monitor
        logic prev_sclk;
        prev_sclk = 1'b1;
        forever begin
            @(negedge CLK);
            if (ACLR_L && !prev_sclk && SCLK) rx_q.push_back(SDATA);
            if (DONE) done_cnt++;
            prev_sclk = SCLK;
        end
    end

    // Loopback receiver: 2-FF synchronizer plus rising-edge sampler.
    initial begin : lb_receiver
        logic c1, c2, c3, d1, d2;
        logic [FB-1:0] w;
        logic [DW-1:0] exp_d;
        int nb;
        c1 = 1'b1; c2 = 1'b1; c3 = 1'b1; d1 = 1'b1; d2 = 1'b1; w = '0; nb = 0;
        forever begin
            @(negedge CLK);
            if (lb_done) lb_done_cnt++;
            if (lb_busy) lb_busy_cyc++;
            c3 = c2; c2 = c1; c1 = lb_sclk;
            d2 = d1; d1 = lb_sdata;
            if (c2 && !c3) begin
                w[nb] = d2;
                nb++;
                if (nb == FB) begin
                    nb = 0;
                    check("lb_word_expected", int'(lb_sent.size() > 0), 1);
                    if (lb_sent.size() > 0) begin
                        exp_d = lb_sent.pop_front();
                        check("lb_word", int'(w), int'(frame_of(exp_d)));
                    end
                    lb_rx++;
                end
            end
        end
    end

    // Loopback requester: random words with random idle spacing.
    initial begin : lb_driver
        int n;
        lb_rst_n = 1'b0; lb_valid = 1'b0; lb_data = '0;
        repeat (3) @(posedge CLK);
        #2 lb_rst_n = 1'b1;
        for (int i = 0; i < LB_N; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            @(posedge CLK); #2;
            n = 0;
            while (!lb_ready && n < 1000) begin @(posedge CLK); #2; n++; end
            lb_data  = DW'($urandom);
            lb_valid = 1'b1;
            lb_sent.push_back(lb_data);
            @(posedge CLK); #2;
            lb_valid = 1'b0;
        end
    end

    task automatic send(input logic [DW-1:0] d, output longint acc_t);
        int n;
        n = 0;
        @(posedge CLK); #2;
        while (!TX_READY && n < 1000) begin @(posedge CLK); #2; n++; end
        check("send_ready_seen", int'(TX_READY), 1);
        TX_VALID = 1'b1; TX_DATA = d;
        @(posedge CLK);
        acc_t = $time;
        #2;
        TX_VALID = 1'b0; TX_DATA = DW'($urandom);
    endtask

    // Returns at the negedge where DONE is seen (bounded).
    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (!DONE && n < 4 * L) begin @(negedge CLK); n++; end
        check({name, "_done_seen"}, int'(DONE), 1);
    endtask

    initial begin : main
        longint acc_t;
        int n, snap;
        ACLR_L = 1'b0; TX_VALID = 1'b0; TX_DATA = '0;
        repeat (5) @(posedge CLK);
        #2;
        check("reset_state", int'({TX_READY, SCLK, SDATA, BUSY, DONE}), 32'h1C);
        ACLR_L = 1'b1;

        // Single frame 0xA5.
        rx_q.delete();
        send(8'hA5, acc_t);
        wait_done("a5");
        check("a5_done_latency", int'(($time - 5 - acc_t) / 10), PAR ? 88 : 80);
        check("a5_bits", int'(rx_frame(0)), PAR ? 32'h74A : 32'h34A);
        check("a5_bit_count", rx_q.size(), PAR ? 11 : 10);
        n = 0;
        while (!TX_READY && n < 50) begin @(negedge CLK); n++; end
        check("a5_ready_after_done", n, 4);

        // Single frame 0x00.
        rx_q.delete();
        send(8'h00, acc_t);
        wait_done("zero");
        check("zero_done_latency", int'(($time - 5 - acc_t) / 10), PAR ? 88 : 80);
        check("zero_bits", int'(rx_frame(0)), PAR ? 32'h600 : 32'h200);

        // Back-to-back with TX_VALID held high; pulses during BUSY ignored.
        repeat (GC + 2) @(posedge CLK);
        rx_q.delete();
        snap = done_cnt;
        #2;
        TX_VALID = 1'b1; TX_DATA = 8'h3C;
        @(posedge CLK); #2;
        TX_DATA = 8'hC3;
        wait_done("b2b_first");
        n = 0;
        while (SCLK && n < 50) begin @(negedge CLK); n++; end
        check("b2b_start_after_done", n, GC + 1);
        for (int i = 0; i < L - 10; i++) begin
            @(posedge CLK); #2;
            TX_VALID = 1'($urandom_range(0, 1)); TX_DATA = DW'($urandom);
        end
        TX_VALID = 1'b0;
        wait_done("b2b_second");
        repeat (L / 2) @(posedge CLK);
        check("b2b_frame_count", done_cnt - snap, 2);
        check("b2b_first_word", int'(rx_frame(0)), int'(frame_of(8'h3C)));
        check("b2b_second_word", int'(rx_frame(FB)), int'(frame_of(8'hC3)));
        check("b2b_bit_count", rx_q.size(), 2 * FB);

        // Reset in the middle of a 0xFF frame, then 0x81.
        snap = done_cnt;
        send(8'hFF, acc_t);
        repeat (2 * CD * 4) @(posedge CLK);
        #2 ACLR_L = 1'b0;
        #1;
        check("midreset_lines_high", int'({SCLK, SDATA, BUSY, TX_READY}), 32'hD);
        repeat (3) @(posedge CLK);
        #2 ACLR_L = 1'b1;
        repeat (L + GC) @(posedge CLK);
        check("midreset_no_done", done_cnt - snap, 0);
        rx_q.delete();
        send(8'h81, acc_t);
        wait_done("after_reset");
        check("after_reset_latency", int'(($time - 5 - acc_t) / 10), L);
        check("after_reset_word", int'(rx_frame(0)), int'(frame_of(8'h81)));

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 2500; i++) begin
            @(posedge CLK); #2;
            TX_VALID = ($urandom_range(0, 3) != 0);
            TX_DATA  = DW'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                ACLR_L = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #2 ACLR_L = 1'b1;
            end
        end
        TX_VALID = 1'b0;
        repeat (L + GC + 5) @(posedge CLK);

        // Loopback completion.
        n = 0;
        while (lb_rx < LB_N && n < 40000) begin @(posedge CLK); n++; end
        repeat (10) @(posedge CLK);
        check("lb_words_received", lb_rx, LB_N);
        check("lb_done_pulses", lb_done_cnt, LB_N);
        check("lb_busy_cycles", lb_busy_cyc, LB_N * 2 * LB_CD * FB);
        check("lb_queue_drained", lb_sent.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
